sma_stream: RTL

- Parametrised simple-moving-average filter for signed sample streams. It generalises the fixed 4-tap, 16-bit SMA.
- Window depth is 2^LOG2_TAPS and sample width is DATA_W.
- Input and output use valid/ready handshakes, so the filter can be stalled.
- MODE selects either zero-history warm-up or suppression of output until the window is full. A synchronous clear allows re-arming between frames.
- Sits in the sample datapath between an ADC/stream source and downstream DSP.

---
 rtl/sma_stream.sv | 94 +++++++++
 1 files changed

// File: rtl/sma_stream.sv
// sma_stream: simple moving average over the last 2^LOG2_TAPS signed samples.
// A circular history buffer feeds a running sum. The floored average is
// delivered through a single-entry output register with valid/ready flow control.
//
// Handshake rules, identical on both sides:
//   - A transfer happens on a rising clk edge where valid && ready.
//   - valid and its data are held stable until that transfer.
//   - in_ready depends only on clear, out_valid and out_ready, never on in_valid.
module sma_stream #(
    parameter int DATA_W    = 16,
    parameter int LOG2_TAPS = 2,
    parameter int MODE      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              full
);

    localparam int TAPS  = 1 << LOG2_TAPS;
    localparam int SUM_W = DATA_W + LOG2_TAPS;
    localparam int CNT_W = LOG2_TAPS + 1;
    localparam logic [CNT_W-1:0] TAPS_CNT = CNT_W'(TAPS);

    logic [DATA_W-1:0]       hist [TAPS];
    logic [LOG2_TAPS-1:0]    wp;
    logic [CNT_W-1:0]        fill;
    logic signed [SUM_W-1:0] sum;

    logic signed [SUM_W-1:0]  in_ext;
    logic signed [SUM_W-1:0]  old_ext;
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [DATA_W-1:0] avg;
    logic [CNT_W-1:0]         fill_next;
    logic                     accept;
    logic                     emit;

    // The output register can take a new result when it is empty or is being popped now.
    assign in_ready = !clear && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign full     = (fill == TAPS_CNT);

    // Next running sum, floored average and fill count for the sample on in_data.
    always_comb begin
        in_ext    = {{LOG2_TAPS{in_data[DATA_W-1]}}, in_data};
        old_ext   = {{LOG2_TAPS{hist[wp][DATA_W-1]}}, hist[wp]};
        sum_next  = sum + in_ext - old_ext;
        avg       = DATA_W'(sum_next >>> LOG2_TAPS);
        fill_next = (fill == TAPS_CNT) ? fill : fill + CNT_W'(1);
        emit      = accept && ((MODE == 0) || (fill_next == TAPS_CNT));
    end

    // Window state: history buffer, write pointer, running sum and fill count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) hist[i] <= '0;
            wp   <= '0;
            sum  <= '0;
            fill <= '0;
        end else if (clear) begin
            for (int i = 0; i < TAPS; i++) hist[i] <= '0;
            wp   <= '0;
            sum  <= '0;
            fill <= '0;
        end else if (accept) begin
            hist[wp] <= in_data;
            wp       <= wp + LOG2_TAPS'(1);
            sum      <= sum_next;
            fill     <= fill_next;
        end
    end

    // Single-entry output register. A pop and a load in the same cycle leave no bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_data  <= avg;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
